// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing a one-bit 4:1 mux between four requesters.
// Optional forced release after MAX_HOLD cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_4x1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       out,
    output logic       out_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject configurations where the hold counter cannot reach MAX_HOLD-1
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (32'd1 << CNT_W) <= (MAX_HOLD - 1)) begin : g_bad_cfg
        $error("mux_4x1_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       timeout_nxt;
    logic [1:0] owner;
    logic       arb_go;
    logic [3:0] arb_req;
    logic [1:0] arb_ptr;
    logic [2:0] pick_res;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
`endif

    // The registered selects double as the owner index
    assign owner = {s0, s1};

    // First requester at or after p, wrapping; bit 2 flags that one was found
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        sel_nxt     = owner;
        timeout_nxt = 1'b0;
        arb_go      = 1'b0;
        arb_req     = req;
        arb_ptr     = ptr;
        pick_res    = 3'b000;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_nxt    = hold_cnt;
`endif

        case (state)
            IDLE: begin
                if (|req) begin
                    arb_go = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    ptr_nxt = owner + 2'd1;
                    arb_ptr = owner + 2'd1;
                    arb_go  = 1'b1;
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    ptr_nxt     = owner + 2'd1;
                    arb_ptr     = owner + 2'd1;
                    arb_req     = req & ~(4'b0001 << owner);
                    arb_go      = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                sel_nxt   = 2'b00;
            end
        endcase

        if (arb_go) begin
            pick_res = pick(arb_req, arb_ptr);
`ifdef MUX_ARB_TIMEOUT_EN
            hold_nxt = '0;
`endif
            if (pick_res[2]) begin
                state_nxt = GRANT;
                gnt_nxt   = 4'b0001 << pick_res[1:0];
                sel_nxt   = pick_res[1:0];
            end else if (!timeout_nxt) begin
                // Forced release with no competitor keeps the owner; otherwise go idle
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                sel_nxt   = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'b00;
            gnt       <= 4'b0000;
            s0        <= 1'b0;
            s1        <= 1'b0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            s0        <= sel_nxt[1];
            s1        <= sel_nxt[0];
            out_valid <= |gnt_nxt;
            timeout   <= timeout_nxt;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end
`endif

    // Data path: same select encoding as the downstream gate-level mux
    always_comb begin
        case ({s0, s1})
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            default: out = d;
        endcase
    end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Self-checking bench for mux_4x1_rr_arbiter; follows MUX_ARB_TIMEOUT_EN if defined.
module tb_mux_4x1_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CNT_W    = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       a, b, c, d;
    logic [3:0] gnt;
    logic       s0, s1, out, out_valid, timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic       s0;
        logic       s1;
        logic       out;
        logic       out_valid;
        logic       timeout;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: owner -1 means nobody holds the mux
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    mux_4x1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .s0(s0), .s1(s1), .out(out),
        .out_valid(out_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.gnt = gnt; o.s0 = s0; o.s1 = s1; o.out = out;
        o.out_valid = out_valid; o.timeout = timeout;
        return o;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0;
        sb.delete();
    endtask

    // Drive one cycle, push the expected post-edge outputs, sample #1 after the edge
    task automatic drive_cycle(input logic [3:0] r, input logic [3:0] dat);
        obs_t       e;
        int         nxt;
        logic [3:0] masked;
        logic       to;
        @(negedge clk);
        req = r;
        {d, c, b, a} = dat;
        to  = 1'b0;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r != 4'b0000) nxt = first_req(r, m_ptr);
            m_hold = 0;
        end else if (!r[m_owner]) begin
            m_ptr  = (m_owner + 1) % 4;
            nxt    = first_req(r, m_ptr);
            m_hold = 0;
        end else if (TO_EN && m_hold == int'(MAX_HOLD) - 1) begin
            m_ptr  = (m_owner + 1) % 4;
            masked = r;
            masked[m_owner] = 1'b0;
            nxt    = (masked != 4'b0000) ? first_req(masked, m_ptr) : m_owner;
            m_hold = 0;
            to     = 1'b1;
        end else if (m_hold < 15) begin
            m_hold++;
        end
        m_owner = nxt;
        e.gnt       = (nxt >= 0) ? 4'(1 << nxt) : 4'b0000;
        e.s0        = (nxt >= 0) ? nxt[1] : 1'b0;
        e.s1        = (nxt >= 0) ? nxt[0] : 1'b0;
        e.out       = dat[(nxt >= 0) ? nxt : 0];
        e.out_valid = (nxt >= 0);
        e.timeout   = to;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = 4'b1111;
        {d, c, b, a} = 4'b0001;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({gnt, s0, s1, out_valid, timeout, out} !== {4'b0000, 4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL reset: got gnt=%b s0=%b s1=%b vld=%b to=%b out=%b, exp all 0, out=1",
                     gnt, s0, s1, out_valid, timeout, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        model_reset();
    endtask

    task automatic test_single();
        obs_t e, o;
        drive_cycle(4'b0100, 4'b0100);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e || gnt !== 4'b0100 || out !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: got %b exp %b", o, e);
        end
        drive_cycle(4'b0000, 4'b0100);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL single_release: got %b exp %b", o, e);
        end
    endtask

    task automatic test_rotation();
        obs_t e, o;
        apply_reset();
        drive_cycle(4'b1111, 4'($urandom));
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL rotate_first: got %b exp %b", o, e);
        end
        for (int j = 0; j < 4; j++) begin
            drive_cycle(4'b1111, 4'($urandom));
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rotate_hold%0d: got %b exp %b", j, o, e);
            end
            drive_cycle(4'b1111 & ~4'(1 << j), 4'($urandom));
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e || gnt !== 4'(1 << ((j + 1) % 4))) begin
                n_err++;
                $display("FAIL rotate_next%0d: got %b exp %b", j, o, e);
            end
        end
    endtask

    task automatic test_timeout_pair();
        obs_t e, o;
        int   run = 0;
        bit   counting = 1'b1;
        int   exp_run;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive_cycle(4'b0011, 4'($urandom));
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL timeout_pair%0d: got %b exp %b", i, o, e);
            end
            if (counting && gnt == 4'b0001) run++;
            else counting = 1'b0;
        end
        exp_run = TO_EN ? 4 : 12;
        n_vec++;
        if (run !== exp_run) begin
            n_err++;
            $display("FAIL timeout_pair_run: got %0d cycles exp %0d", run, exp_run);
        end
    endtask

    task automatic test_timeout_single();
        obs_t e, o;
        int   pulses = 0;
        int   exp_pulses;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(4'b0001, 4'($urandom));
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e || gnt !== 4'b0001) begin
                n_err++;
                $display("FAIL timeout_single%0d: got %b exp %b", i, o, e);
            end
            if (timeout === 1'b1) pulses++;
        end
        exp_pulses = TO_EN ? 2 : 0;
        n_vec++;
        if (pulses !== exp_pulses) begin
            n_err++;
            $display("FAIL timeout_single_pulses: got %0d exp %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        apply_reset();
        drive_cycle(4'b1000, 4'b1000);
        drive_cycle(4'b1010, 4'b1010);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL async_pre%0d: got %b exp %b", i, o, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({gnt, s0, s1, out_valid, timeout} !== 8'b0) begin
            n_err++;
            $display("FAIL async_clear: got gnt=%b s0=%b s1=%b vld=%b to=%b exp 0",
                     gnt, s0, s1, out_valid, timeout);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1010, 4'b0010);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL async_regrant: got %b exp %b", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout_pair();
        test_timeout_single();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
